// File: rtl/ls_pkg.sv
// Shared definitions for the ls595 shift/latch slice: default width and the
// helper that sizes the shift counter so it can hold the value WIDTH.
package ls_pkg;

  localparam int LS595_WIDTH_DEFAULT = 8;

  // Bits needed to count from 0 up to and including w.
  function automatic int cnt_w(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ls_reg_bank.sv
// WIDTH-bit register with load enable and asynchronous active-low reset.
// Holds the storage (output) register of the ls595 model.
module ls_reg_bank
  import ls_pkg::*;
#(
  parameter int WIDTH = LS595_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on any edge where load is high; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ls595_shift_latch.sv
// 74LS595-style serial-in / parallel-out shift register with a storage latch,
// all on one clock with strobe qualification.
// Build option: define LS595_TRISTATE_EN to drive q to high-Z while oe_n=1;
// otherwise q is forced to zero while oe_n=1 (no tristate drivers).
// Strobes are level-sampled on each rising clk edge: shift_en, latch_en and
// sclr_n each act on the edge where they are seen active; there is no
// handshake and no back-pressure.
module ls595_shift_latch
  import ls_pkg::*;
#(
  parameter int WIDTH = LS595_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser,
  input  logic             shift_en,
  input  logic             latch_en,
  input  logic             sclr_n,
  input  logic             oe_n,
  output logic [WIDTH-1:0] q,
  output logic             qh_s,
  output logic             full
);

  localparam int              CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] store_reg;
  logic [CW-1:0]    cnt;

  // Shift register: synchronous clear wins over shifting; ser enters bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (!sclr_n) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WIDTH-2:0], ser};
    end
  end

  // Shift counter: a latch restarts the count, so a shift on the same edge
  // becomes the first bit of the next word; counting saturates at WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!sclr_n) begin
      cnt <= '0;
    end else if (latch_en && shift_en) begin
      cnt <= CW'(1);
    end else if (latch_en) begin
      cnt <= '0;
    end else if (shift_en) begin
      cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end
  end

  // Storage register captures the pre-edge shift_reg value, so a latch on
  // the same edge as a shift or clear sees the old contents.
  ls_reg_bank #(
    .WIDTH (WIDTH)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (latch_en),
    .d     (shift_reg),
    .q     (store_reg)
  );

  assign qh_s = shift_reg[WIDTH-1];
  assign full = (cnt == CNT_MAX);

`ifdef LS595_TRISTATE_EN
  assign q = oe_n ? {WIDTH{1'bz}} : store_reg;
`else
  assign q = oe_n ? {WIDTH{1'b0}} : store_reg;
`endif

endmodule

// File: tb/tb_ls595_shift_latch.sv
// Directed bench for ls595_shift_latch (WIDTH=8). Drivers push the expected
// {q, qh_s, full} after each action; a monitor on the falling edge pops and
// compares.
module tb_ls595_shift_latch;

  localparam int W = 8;

`ifdef LS595_TRISTATE_EN
  localparam logic [W-1:0] Q_OFF = {W{1'bz}};
`else
  localparam logic [W-1:0] Q_OFF = '0;
`endif

  logic         clk;
  logic         rst_n;
  logic         ser;
  logic         shift_en;
  logic         latch_en;
  logic         sclr_n;
  logic         oe_n;
  logic [W-1:0] q;
  logic         qh_s;
  logic         full;

  logic [W+1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  ls595_shift_latch #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser      (ser),
    .shift_en (shift_en),
    .latch_en (latch_en),
    .sclr_n   (sclr_n),
    .oe_n     (oe_n),
    .q        (q),
    .qh_s     (qh_s),
    .full     (full)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard push
  task automatic expect_out(input logic [W-1:0] eq, input logic eqh,
                            input logic ef, input string nm);
    exp_q.push_back({eq, eqh, ef});
    name_q.push_back(nm);
  endtask

  // one clocked action; strobes return to idle right after the edge
  task automatic step(input logic s, input logic sh, input logic la,
                      input logic sc, input logic [W-1:0] eq,
                      input logic eqh, input logic ef, input string nm);
    ser = s; shift_en = sh; latch_en = la; sclr_n = sc;
    @(posedge clk);
    #1;
    expect_out(eq, eqh, ef, nm);
    ser = 1'b0; shift_en = 1'b0; latch_en = 1'b0; sclr_n = 1'b1;
  endtask

  // combinational oe_n change, away from the previous check window
  task automatic set_oe(input logic v, input logic [W-1:0] eq,
                        input logic eqh, input logic ef, input string nm);
    @(posedge clk);
    #2;
    oe_n = v;
    #1;
    expect_out(eq, eqh, ef, nm);
  endtask

  // monitor: compare every pending expectation on the falling edge
  always @(negedge clk) begin
    logic [W+1:0] e;
    string        nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if ({q, qh_s, full} !== e) begin
        errors++;
        $display("FAIL %s: got q=%h qh_s=%b full=%b, want q=%h qh_s=%b full=%b",
                 nm, q, qh_s, full, e[W+1:2], e[1], e[0]);
      end
    end
  end

  // stimulus
  initial begin
    logic [W-1:0] bits;
    logic [W-1:0] qh_pat;
    int           wait_cnt;

    rst_n = 1'b0; ser = 1'b0; shift_en = 1'b0; latch_en = 1'b0;
    sclr_n = 1'b1; oe_n = 1'b0;

    // reset held with random strobes
    for (int i = 0; i < 4; i++) begin
      ser      = 1'($urandom_range(0, 1));
      shift_en = 1'($urandom_range(0, 1));
      latch_en = 1'($urandom_range(0, 1));
      sclr_n   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      expect_out(8'h00, 1'b0, 1'b0, "reset_hold");
    end
    ser = 1'b0; shift_en = 1'b0; latch_en = 1'b0; sclr_n = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expect_out(8'h00, 1'b0, 1'b0, "reset_idle");
    end

    // serial load of A5, MSB first
    bits = 8'hA5;
    for (int i = 0; i < 8; i++)
      step(bits[7-i], 1'b1, 1'b0, 1'b1, 8'h00, (i == 7), (i == 7), "load_a5");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, "latch_a5");

    // load 3C over A5 (qh_s shows the old A5 bits leaving)
    bits   = 8'h3C;
    qh_pat = 8'b0101_0010;
    for (int i = 0; i < 8; i++)
      step(bits[7-i], 1'b1, 1'b0, 1'b1, 8'hA5, qh_pat[i], (i == 7), "load_3c");

    // simultaneous shift and latch: q=3C, shift_reg=79, cnt=1
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, "shift_and_latch");
    // seven more ones: full exactly on the 7th (cnt started at 1), reg -> FF
    qh_pat = 8'b0100_1111;
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, qh_pat[i], (i == 6), "cnt_from_one");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "latch_79_shifted");

    // reload FF then clear with shift and latch also asserted
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, (i == 7), "reload_ff");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, "sclr_priority");

    // 12 ones without latching: full and qh_s from edge 8 on
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, (i >= 7), (i >= 7), "saturate");

    // set up store_reg = 5A
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, "clear_only");
    bits = 8'h5A;
    for (int i = 0; i < 8; i++)
      step(bits[7-i], 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, (i == 7), "load_5a");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, "latch_5a");

    // output enable, shifting continues while q is disabled
    set_oe(1'b1, Q_OFF, 1'b0, 1'b0, "oe_off");
    set_oe(1'b0, 8'h5A, 1'b0, 1'b0, "oe_on");
    set_oe(1'b1, Q_OFF, 1'b0, 1'b0, "oe_off2");
    step(1'b1, 1'b1, 1'b0, 1'b1, Q_OFF, 1'b1, 1'b0, "shift_oe_off_b5");
    step(1'b0, 1'b1, 1'b0, 1'b1, Q_OFF, 1'b0, 1'b0, "shift_oe_off_6a");
    set_oe(1'b0, 8'h5A, 1'b0, 1'b0, "oe_on2");

    // asynchronous reset mid-word
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expect_out(8'h00, 1'b0, 1'b0, "async_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "post_reset_shift");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "post_reset_latch");

    // drain scoreboard with a bounded wait
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls595_shift_latch.md
# ls595_shift_latch

Synchronous model of a 74LS595-style serial-in, parallel-out shift register with an output storage latch. It sits directly upstream of the quad AND gate library part. It deserialises a bit stream and presents a stable parallel word whose bits drive the gate inputs (a1..a4, b1..b4). Shifting and latching are strobe-qualified on one system clock rather than on separate SRCLK/RCLK pins. A shift-count tracker flags when a full word has been shifted in since the last latch.

## Interface
- WIDTH, 8, shift/storage register width in bits; legal range 2..32
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset; asynchronous and active-low
- ser  in  1  serial data input, sampled when shift_en=1
- shift_en  in  1  shift strobe; SRCLK equivalent
- latch_en  in  1  storage strobe; RCLK equivalent
- sclr_n  in  1  synchronous clear of shift register and count, active-low; SRCLR equivalent
- oe_n  in  1  output enable, active-low; OE equivalent
- q  out  WIDTH  parallel storage-register outputs (QA..QH)
- qh_s  out  1  serial cascade output (QH'), equal to shift_reg[WIDTH-1]
- full  out  1  high when WIDTH shifts have occurred since the last latch or clear

## Operation
- State:
  - shift_reg[WIDTH-1:0]
  - store_reg[WIDTH-1:0]
  - cnt, $clog2(WIDTH+1) bits
- Reset (rst_n=0, asynchronous): shift_reg=0, store_reg=0, cnt=0. Outputs: q=0, or high-Z if the tristate build is selected and oe_n=1. qh_s=0, full=0.
- Shift: if shift_en=1 and sclr_n=1, then shift_reg <= {shift_reg[WIDTH-2:0], ser}. ser enters bit 0; bit WIDTH-1 is discarded.
- Clear: if sclr_n=0, then shift_reg <= 0 and cnt <= 0. Clear has priority over shift_en. store_reg is unaffected.
- Latch: if latch_en=1, then store_reg <= shift_reg as it was before this edge (pre-shift, pre-clear value).
- Count, applied in priority order:
  - sclr_n=0: cnt <= 0
  - latch_en=1 and shift_en=1: cnt <= 1
  - latch_en=1 only: cnt <= 0
  - shift_en=1 only: cnt <= min(cnt+1, WIDTH), saturating
- full = (cnt == WIDTH); combinational from cnt.
- oe_n affects only q. It never gates shifting, latching or qh_s.

## Timing
- Each shift, latch or clear takes effect one clk edge after its strobe is sampled high.
- Latency from ser to q:
  - minimum: one shift edge, then one latch edge on a later cycle
  - simultaneous shift_en and latch_en: the latch captures the old contents, and the new bit reaches q only on the next latch
- qh_s changes on the same edge as shift_reg.
- oe_n to q is combinational, with zero cycles of latency.
- rst_n assertion clears state immediately. Deassertion is synchronised externally, and the first active edge follows the release.
- Reset mid-word: cnt and all bits return to 0, and any partially shifted word is lost.

## Configuration
- LS595_TRISTATE_EN defined: q = oe_n ? 'z : store_reg. This models the real part on a shared bus.
- LS595_TRISTATE_EN undefined: q = oe_n ? 0 : store_reg. There are no high-Z drivers, so the build is synthesis-safe for FPGA internal nets.

## Structure
- Shared package ls_pkg holds:
  - LS595_WIDTH_DEFAULT = 8
  - a count-width helper: function cnt_w(int w) returns $clog2(w+1)
- Sub-module ls_reg_bank: a WIDTH-bit enable-load register with async active-low reset, used for store_reg. shift_reg and cnt stay in the top module.

## Test plan
- Reset: hold rst_n=0 with oe_n=0 and random strobes. Required: q=8'h00, qh_s=0, full=0. Deassert, then idle 3 cycles: all outputs remain 0.
- Serial load and latch: shift 8 bits of 8'hA5, MSB first. full=1 after the 8th edge. Pulse latch_en: q=8'hA5 and full=0. Shifted data is still present, so qh_s equals the current shift_reg[7].
- Simultaneous shift and latch: with shift_reg=8'h3C, assert shift_en=1, ser=1 and latch_en=1 in the same cycle. Required: q=8'h3C, shift_reg becomes 8'h79, cnt=1.
- Sync clear priority: with shift_reg=8'hFF, assert sclr_n=0, shift_en=1 and latch_en=1. Required: q=8'hFF, shift_reg=0, cnt=0, qh_s=0.
- Count saturation and cascade: shift 12 ones without latching. Required: full stays 1 from edge 8 through edge 12, and qh_s=1 from edge 8.
- Output enable: with store_reg=8'h5A, toggle oe_n. Tristate build: q alternates between 'z and 8'h5A. Default build: q alternates between 8'h00 and 8'h5A. In both builds, shifting during oe_n=1 still updates qh_s.
